prim_fifo_sync_wm: RTL and testbench

//  Synchronous single-clock FIFO that generalises the basic prim sync FIFO with the following additions:
//   - any Depth >= 1 (no power-of-2 restriction)
//   - runtime almost-full / almost-empty watermarks
//   - explicit empty flag
//   - optional drop-on-full mode with a saturating drop counter

---
 rtl/prim_fifo_sync_wm.sv | 141 ++++++++++++++
 tb/tb_prim_fifo_sync_wm.sv | 286 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/prim_fifo_sync_wm.sv
// prim_fifo_sync_wm: single-clock FIFO with any depth (not just a power of 2).
// It adds runtime almost-full/almost-empty watermarks, an explicit empty flag,
// an optional same-cycle pass-through, and an optional drop-on-full mode with a
// saturating counter of dropped writes.
module prim_fifo_sync_wm #(
    parameter int unsigned Width             = 16,
    parameter int unsigned Depth             = 8,
    parameter bit          Pass              = 1'b1,
    parameter bit          OutputZeroIfEmpty = 1'b1,
    parameter bit          DropOnFull        = 1'b0,
    parameter int unsigned DropCntW          = 8,
    localparam int unsigned DepthW           = $clog2(Depth + 1)
) (
    input  logic                clk_i,
    input  logic                rst_ni,
    input  logic                clr_i,
    input  logic                wvalid_i,
    output logic                wready_o,
    input  logic [Width-1:0]    wdata_i,
    output logic                rvalid_o,
    input  logic                rready_i,
    output logic [Width-1:0]    rdata_o,
    output logic                full_o,
    output logic                empty_o,
    output logic [DepthW-1:0]   depth_o,
    input  logic [DepthW-1:0]   afull_thresh_i,
    input  logic [DepthW-1:0]   aempty_thresh_i,
    output logic                afull_o,
    output logic                aempty_o,
    output logic [DropCntW-1:0] drop_cnt_o
);

    localparam int unsigned PtrW = (Depth > 1) ? $clog2(Depth) : 1;

    if (Depth < 1) begin : gen_depth_check
        $error("prim_fifo_sync_wm: Depth must be at least 1");
    end

    logic [PtrW-1:0]     rptr_q;
    logic [PtrW-1:0]     wptr_q;
    logic [DepthW-1:0]   count_q;
    logic [DropCntW-1:0] drop_cnt_q;
    logic                under_rst_q;
    logic [Width-1:0]    storage [Depth];
    logic [Width-1:0]    rdata_raw;
    logic                full;
    logic                empty;
    logic                push;
    logic                pop;
    logic                drop;

    // Pointers wrap at Depth-1 instead of relying on natural binary overflow.
    function automatic logic [PtrW-1:0] ptr_inc(input logic [PtrW-1:0] p);
        if (p == PtrW'(Depth - 1)) begin
            return '0;
        end
        return p + 1'b1;
    endfunction

    // Status flags come from the occupancy counter, never from pointer compares.
    assign full    = (count_q == DepthW'(Depth));
    assign empty   = (count_q == '0);
    assign full_o  = full;
    assign empty_o = empty;
    assign depth_o = count_q;
    assign afull_o  = (count_q >= afull_thresh_i);
    assign aempty_o = (count_q <= aempty_thresh_i);
    assign drop_cnt_o = drop_cnt_q;

    // Handshakes are held off for the first edge after reset release.
    assign wready_o = ~under_rst_q & (DropOnFull ? 1'b1 : ~full);
    assign rvalid_o = ~under_rst_q & (~empty | (Pass & wvalid_i));
    assign pop      = rvalid_o & rready_i;
    assign push     = DropOnFull ? (wvalid_i & ~under_rst_q & (~full | pop))
                                 : (wvalid_i & wready_o);
    assign drop     = DropOnFull & wvalid_i & ~under_rst_q & full & ~pop;

    // Read data comes from storage, or straight from the write port when empty
    // in pass-through mode; optionally forced to zero when nothing is valid.
    always_comb begin
        rdata_raw = storage[rptr_q];
        if (Pass && empty) begin
            rdata_raw = wdata_i;
        end
        rdata_o = rdata_raw;
        if (OutputZeroIfEmpty && !rvalid_o) begin
            rdata_o = '0;
        end
    end

    // Control state: pointers, occupancy count, drop counter and the reset guard.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            rptr_q      <= '0;
            wptr_q      <= '0;
            count_q     <= '0;
            drop_cnt_q  <= '0;
            under_rst_q <= 1'b1;
        end else begin
            under_rst_q <= 1'b0;
            if (clr_i) begin
                rptr_q     <= '0;
                wptr_q     <= '0;
                count_q    <= '0;
                drop_cnt_q <= '0;
            end else begin
                if (push) begin
                    wptr_q <= ptr_inc(wptr_q);
                end
                if (pop) begin
                    rptr_q <= ptr_inc(rptr_q);
                end
                if (push && !pop) begin
                    count_q <= count_q + DepthW'(1);
                end else if (pop && !push) begin
                    count_q <= count_q - DepthW'(1);
                end
                if (drop && (drop_cnt_q != '1)) begin
                    drop_cnt_q <= drop_cnt_q + DropCntW'(1);
                end
            end
        end
    end

    // Data storage has no reset; a flush suppresses the same-cycle write.
    always_ff @(posedge clk_i) begin
        if (push && !clr_i) begin
            storage[wptr_q] <= wdata_i;
        end
    end

    a_depth_bound: assert property (@(posedge clk_i) disable iff (!rst_ni)
        count_q <= DepthW'(Depth));
    a_no_overflow: assert property (@(posedge clk_i) disable iff (!rst_ni)
        (push && full) |-> pop);
    a_no_underflow: assert property (@(posedge clk_i) disable iff (!rst_ni)
        (pop && empty) |-> (Pass && push));
    a_rdata_known: assert property (@(posedge clk_i) disable iff (!rst_ni)
        rvalid_o |-> !$isunknown(rdata_o));

endmodule

// File: tb/tb_prim_fifo_sync_wm.sv
// Testbench for prim_fifo_sync_wm. Three instances share clock, reset and clear:
//   dut0: Depth 8, pass-through on
//   dut1: Depth 5 (non power of 2), pass-through off
//   dut2: Depth 4, drop-on-full mode
// A queue-based reference model predicts occupancy, flags and dropped writes.
// A separate monitor pops expected read data whenever a DUT completes a read.
module tb_prim_fifo_sync_wm;

    logic clk_i = 1'b0;
    logic rst_ni;
    logic clr_i;

    logic        wvalid [3];
    logic [15:0] wdata  [3];
    logic        rready [3];
    logic        wready [3];
    logic        rvalid [3];
    logic [15:0] rdata  [3];
    logic        full   [3];
    logic        empty  [3];
    logic        afull  [3];
    logic        aempty [3];
    logic [7:0]  dropCnt [3];

    logic [3:0] depthA, afThA, aeThA;
    logic [2:0] depthB, afThB, aeThB;
    logic [2:0] depthC, afThC, aeThC;

    int afTh [3];
    int aeTh [3];

    int depthOf [3] = '{8, 5, 4};
    bit passOf  [3] = '{1'b1, 1'b0, 1'b0};
    bit dropOf  [3] = '{1'b0, 1'b0, 1'b1};

    int          cnt [3];
    int          mdlDrop [3];
    bit          underRst;
    logic [15:0] sbMem [3][4096];
    int          sbHead [3];
    int          sbTail [3];
    bit          pushedNow [3];
    logic [15:0] dataCtr [3];

    int compared;
    int mismatched;

    assign afThA = 4'(afTh[0]);
    assign aeThA = 4'(aeTh[0]);
    assign afThB = 3'(afTh[1]);
    assign aeThB = 3'(aeTh[1]);
    assign afThC = 3'(afTh[2]);
    assign aeThC = 3'(aeTh[2]);

    always #5 clk_i = ~clk_i;

    prim_fifo_sync_wm #(.Width(16), .Depth(8), .Pass(1'b1), .OutputZeroIfEmpty(1'b1),
                        .DropOnFull(1'b0), .DropCntW(8)) dut0 (
        .clk_i(clk_i), .rst_ni(rst_ni), .clr_i(clr_i),
        .wvalid_i(wvalid[0]), .wready_o(wready[0]), .wdata_i(wdata[0]),
        .rvalid_o(rvalid[0]), .rready_i(rready[0]), .rdata_o(rdata[0]),
        .full_o(full[0]), .empty_o(empty[0]), .depth_o(depthA),
        .afull_thresh_i(afThA), .aempty_thresh_i(aeThA),
        .afull_o(afull[0]), .aempty_o(aempty[0]), .drop_cnt_o(dropCnt[0])
    );

    prim_fifo_sync_wm #(.Width(16), .Depth(5), .Pass(1'b0), .OutputZeroIfEmpty(1'b1),
                        .DropOnFull(1'b0), .DropCntW(8)) dut1 (
        .clk_i(clk_i), .rst_ni(rst_ni), .clr_i(clr_i),
        .wvalid_i(wvalid[1]), .wready_o(wready[1]), .wdata_i(wdata[1]),
        .rvalid_o(rvalid[1]), .rready_i(rready[1]), .rdata_o(rdata[1]),
        .full_o(full[1]), .empty_o(empty[1]), .depth_o(depthB),
        .afull_thresh_i(afThB), .aempty_thresh_i(aeThB),
        .afull_o(afull[1]), .aempty_o(aempty[1]), .drop_cnt_o(dropCnt[1])
    );

    prim_fifo_sync_wm #(.Width(16), .Depth(4), .Pass(1'b0), .OutputZeroIfEmpty(1'b1),
                        .DropOnFull(1'b1), .DropCntW(8)) dut2 (
        .clk_i(clk_i), .rst_ni(rst_ni), .clr_i(clr_i),
        .wvalid_i(wvalid[2]), .wready_o(wready[2]), .wdata_i(wdata[2]),
        .rvalid_o(rvalid[2]), .rready_i(rready[2]), .rdata_o(rdata[2]),
        .full_o(full[2]), .empty_o(empty[2]), .depth_o(depthC),
        .afull_thresh_i(afThC), .aempty_thresh_i(aeThC),
        .afull_o(afull[2]), .aempty_o(aempty[2]), .drop_cnt_o(dropCnt[2])
    );

    function automatic int depthOut(input int i);
        case (i)
            0:       return int'(depthA);
            1:       return int'(depthB);
            default: return int'(depthC);
        endcase
    endfunction

    task automatic checkOutput(input string name, input int idx,
                               input longint actual, input longint expected);
        compared++;
        if (actual != expected) begin
            mismatched++;
            $display("[TB] FAIL %s dut%0d at %0t: got %0h, expected %0h",
                     name, idx, $time, actual, expected);
        end
    endtask

    task automatic flushModel();
        for (int i = 0; i < 3; i++) begin
            cnt[i]       = 0;
            mdlDrop[i]   = 0;
            sbHead[i]    = sbTail[i];
            pushedNow[i] = 1'b0;
        end
    endtask

    // Reset asserted asynchronously mid-cycle; released just after an edge so
    // the following cycle is the guarded first cycle.
    task automatic doReset();
        @(negedge clk_i);
        rst_ni = 1'b0;
        clr_i  = 1'b0;
        for (int i = 0; i < 3; i++) begin
            wvalid[i] = 1'b0;
            rready[i] = 1'b0;
        end
        flushModel();
        #1;
        for (int i = 0; i < 3; i++) begin
            checkOutput("rst_depth", i, depthOut(i), 0);
            checkOutput("rst_empty", i, empty[i], 1);
            checkOutput("rst_full", i, full[i], 0);
            checkOutput("rst_dropcnt", i, dropCnt[i], 0);
            checkOutput("rst_wready", i, wready[i], 0);
        end
        repeat (2) @(posedge clk_i);
        #1;
        rst_ni   = 1'b1;
        underRst = 1'b1;
    endtask

    // One clock cycle: drive inputs, check registered state against the model,
    // record accepted writes in the scoreboard, then advance the model.
    task automatic applyStimulus(input logic clr, input logic [2:0] wvMask,
                                 input logic [2:0] rrMask);
        bit rv [3];
        bit pop [3];
        bit acc [3];
        bit drp [3];
        @(negedge clk_i);
        clr_i = clr;
        for (int i = 0; i < 3; i++) begin
            wvalid[i] = wvMask[i];
            wdata[i]  = dataCtr[i];
            rready[i] = rrMask[i] & ~clr;
            afTh[i]   = int'($urandom_range(0, depthOf[i] + 2));
            aeTh[i]   = int'($urandom_range(0, depthOf[i] + 2));
        end
        #1;
        for (int i = 0; i < 3; i++) begin
            checkOutput("depth", i, depthOut(i), cnt[i]);
            checkOutput("empty", i, empty[i], cnt[i] == 0);
            checkOutput("full", i, full[i], cnt[i] == depthOf[i]);
            checkOutput("afull", i, afull[i], cnt[i] >= afTh[i]);
            checkOutput("aempty", i, aempty[i], cnt[i] <= aeTh[i]);
            checkOutput("wready", i, wready[i],
                        !underRst && (dropOf[i] || cnt[i] < depthOf[i]));
            checkOutput("drop_cnt", i, dropCnt[i], mdlDrop[i]);
            rv[i]  = !underRst && (cnt[i] > 0 || (passOf[i] && wvalid[i]));
            pop[i] = rv[i] && rready[i];
            acc[i] = wvalid[i] && !underRst &&
                     (cnt[i] < depthOf[i] || (dropOf[i] && pop[i]));
            drp[i] = dropOf[i] && wvalid[i] && !underRst &&
                     cnt[i] == depthOf[i] && !pop[i];
            pushedNow[i] = acc[i] && !clr;
            if (acc[i] && !clr) begin
                sbMem[i][sbTail[i] % 4096] = wdata[i];
                sbTail[i]++;
            end
            if (wvalid[i]) begin
                dataCtr[i] = dataCtr[i] + 16'd1;
            end
        end
        @(posedge clk_i);
        #1;
        underRst = 1'b0;
        for (int i = 0; i < 3; i++) begin
            pushedNow[i] = 1'b0;
            if (clr) begin
                cnt[i]     = 0;
                mdlDrop[i] = 0;
                sbHead[i]  = sbTail[i];
            end else begin
                cnt[i] = cnt[i] + int'(acc[i]) - int'(pop[i]);
                if (drp[i] && mdlDrop[i] < 255) begin
                    mdlDrop[i]++;
                end
            end
        end
    endtask

    // Monitor: late in the low phase, check read-side outputs and pop expected
    // data for every completed read.
    initial begin
        int avail;
        forever begin
            @(negedge clk_i);
            #2;
            for (int i = 0; i < 3; i++) begin
                avail = sbTail[i] - sbHead[i];
                if (pushedNow[i] && !passOf[i]) begin
                    avail = avail - 1;
                end
                if (!clr_i) begin
                    checkOutput("rvalid", i, rvalid[i], avail > 0);
                end
                if (rvalid[i] && rready[i]) begin
                    if (sbTail[i] == sbHead[i]) begin
                        checkOutput("unexpected_read", i, 1, 0);
                    end else begin
                        checkOutput("rdata", i, rdata[i], sbMem[i][sbHead[i] % 4096]);
                        sbHead[i]++;
                    end
                end else if (!rvalid[i]) begin
                    checkOutput("rdata_zero", i, rdata[i], 0);
                end
            end
        end
    end

    initial begin
        compared   = 0;
        mismatched = 0;
        underRst   = 1'b0;
        rst_ni     = 1'b0;
        clr_i      = 1'b0;
        for (int i = 0; i < 3; i++) begin
            wvalid[i]  = 1'b0;
            wdata[i]   = '0;
            rready[i]  = 1'b0;
            afTh[i]    = 0;
            aeTh[i]    = 0;
            sbHead[i]  = 0;
            sbTail[i]  = 0;
            dataCtr[i] = 16'd1;
        end
        flushModel();
        doReset();
        applyStimulus(1'b0, 3'b111, 3'b000);
        for (int i = 0; i < 3; i++) begin
            dataCtr[i] = 16'h0001;
        end

        $display("[TB] fill to full, then drain in order");
        repeat (9) applyStimulus(1'b0, 3'b111, 3'b000);
        repeat (9) applyStimulus(1'b0, 3'b000, 3'b111);

        $display("[TB] pass-through into empty FIFO");
        dataCtr[0] = 16'hBEEF;
        applyStimulus(1'b0, 3'b001, 3'b001);

        $display("[TB] random interleaved traffic");
        repeat (400) applyStimulus(1'b0, 3'($urandom), 3'($urandom));

        $display("[TB] drop-on-full saturation");
        repeat (9) applyStimulus(1'b0, 3'b000, 3'b111);
        repeat (304) applyStimulus(1'b0, 3'b100, 3'b000);
        applyStimulus(1'b0, 3'b100, 3'b100);
        repeat (5) applyStimulus(1'b0, 3'b000, 3'b100);

        $display("[TB] clear with simultaneous write at depth 3");
        repeat (9) applyStimulus(1'b0, 3'b000, 3'b111);
        repeat (3) applyStimulus(1'b0, 3'b111, 3'b000);
        applyStimulus(1'b1, 3'b111, 3'b000);
        applyStimulus(1'b0, 3'b000, 3'b000);

        $display("[TB] reset in the middle of a burst");
        repeat (50) applyStimulus(1'b0, 3'($urandom), 3'($urandom));
        repeat (3) applyStimulus(1'b0, 3'b111, 3'b000);
        doReset();
        applyStimulus(1'b0, 3'b111, 3'b111);
        repeat (150) applyStimulus(1'b0, 3'($urandom), 3'($urandom));
        repeat (9) applyStimulus(1'b0, 3'b000, 3'b111);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
